// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXI read-burst to BRAM datapath.
// State encoding, default widths and the byte-lane helper used by the writer.
package axis_bram_pkg;

    localparam int AXIS_DATA_WIDTH_DEFAULT = 64;
    localparam int BRAM_ADDR_WIDTH_DEFAULT = 10;
    localparam int LEN_WIDTH_DEFAULT       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_t;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axis_bram_writer.sv
// AXI4-Stream sink that writes each accepted beat into a BRAM port at
// consecutive word addresses, with capacity limit and overflow reporting.
module axis_bram_writer
    import axis_bram_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEFAULT,
    parameter int C_BRAM_ADDR_WIDTH   = BRAM_ADDR_WIDTH_DEFAULT,
    parameter int C_LEN_WIDTH         = LEN_WIDTH_DEFAULT
) (
    input  logic                             s_axis_aclk,
    input  logic                             s_axis_areset,
    input  logic                             arm,
    input  logic [C_BRAM_ADDR_WIDTH-1:0]     base_addr,
    input  logic [C_LEN_WIDTH-1:0]           max_words,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                             s_axis_tlast,
    output logic                             bram_en,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0] bram_we,
    output logic [C_BRAM_ADDR_WIDTH-1:0]     bram_addr,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]   bram_din,
    output logic                             busy,
    output logic                             done,
    output logic [C_LEN_WIDTH-1:0]           word_count,
    output logic                             overflow
);

    localparam int WE_W = byte_lanes(C_S_AXIS_DATA_WIDTH);

    wr_state_t                          state_q, state_d;
    logic [C_BRAM_ADDR_WIDTH-1:0]       base_q, base_d;
    logic [C_LEN_WIDTH-1:0]             max_q, max_d;
    logic [C_LEN_WIDTH-1:0]             word_count_q, word_count_d;
    logic                               overflow_q, overflow_d;
    logic                               tready_q, tready_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               bram_en_q, bram_en_d;
    logic [WE_W-1:0]                    bram_we_q, bram_we_d;
    logic [C_BRAM_ADDR_WIDTH-1:0]       bram_addr_q, bram_addr_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     bram_din_q, bram_din_d;
    logic                               handshake_s;

    // tready is registered from the next state, so it always matches state_q
    assign handshake_s = s_axis_tvalid && tready_q;

    // Next-state and next-output computation for the transfer FSM
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        max_d        = max_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        bram_en_d    = 1'b0;
        bram_we_d    = '0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    if (max_words != '0) begin
                        base_d  = base_addr;
                        max_d   = max_words;
                        state_d = ST_RECV;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (handshake_s) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = '1;
                    bram_addr_d  = base_q + C_BRAM_ADDR_WIDTH'(word_count_q);
                    bram_din_d   = s_axis_tdata;
                    word_count_d = word_count_q + C_LEN_WIDTH'(1);
                    // tlast wins over capacity: an exact fit is not an overflow
                    if (s_axis_tlast) begin
                        state_d = ST_DONE;
                    end else if (word_count_q == max_q - C_LEN_WIDTH'(1)) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DRAIN: begin
                if (handshake_s && s_axis_tlast) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d = (state_d == ST_RECV) || (state_d == ST_DRAIN);
        busy_d   = tready_d;
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers; reset drops any write computed this cycle
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            max_q        <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            tready_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= '0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            max_q        <= max_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign word_count    = word_count_q;
    assign overflow      = overflow_q;
    assign bram_en       = bram_en_q;
    assign bram_we       = bram_we_q;
    assign bram_addr     = bram_addr_q;
    assign bram_din      = bram_din_q;

endmodule

// File: tb/tb_axis_bram_writer.sv
// Directed self-checking bench for axis_bram_writer.
module tb_axis_bram_writer;

    logic        clk;
    logic        areset;
    logic        arm;
    logic [9:0]  base_addr;
    logic [9:0]  max_words;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [63:0] bram_din;
    logic        busy;
    logic        done;
    logic [9:0]  word_count;
    logic        overflow;

    int vectors;
    int miscompares;

    axis_bram_writer #(
        .C_S_AXIS_DATA_WIDTH(64),
        .C_BRAM_ADDR_WIDTH  (10),
        .C_LEN_WIDTH        (10)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_areset(areset),
        .arm          (arm),
        .base_addr    (base_addr),
        .max_words    (max_words),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .s_axis_tdata (tdata),
        .s_axis_tlast (tlast),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .busy         (busy),
        .done         (done),
        .word_count   (word_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_arm(input logic [9:0] base, input logic [9:0] max);
        arm       = 1'b1;
        base_addr = base;
        max_words = max;
        step();
        arm = 1'b0;
        chk("tready_after_arm", 64'(tready), 64'(max != 10'd0));
        chk("busy_after_arm", 64'(busy), 64'(max != 10'd0));
    endtask

    // Present one cycle of stream input and check the registered BRAM port after the edge.
    task automatic beat(input logic v, input logic [63:0] d, input logic l,
                        input logic exp_en, input logic [9:0] exp_addr);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        step();
        chk("bram_en", 64'(bram_en), 64'(exp_en));
        chk("bram_we", 64'(bram_we), exp_en ? 64'hFF : 64'h0);
        if (exp_en) begin
            chk("bram_addr", 64'(bram_addr), 64'(exp_addr));
            chk("bram_din", bram_din, d);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic chk_done(input logic [9:0] exp_wc, input logic exp_ov);
        chk("done_pulse", 64'(done), 64'h1);
        chk("tready_in_done", 64'(tready), 64'h0);
        chk("busy_in_done", 64'(busy), 64'h0);
        chk("word_count", 64'(word_count), 64'(exp_wc));
        chk("overflow", 64'(overflow), 64'(exp_ov));
        step();
        chk("done_falls", 64'(done), 64'h0);
        chk("bram_en_idle", 64'(bram_en), 64'h0);
        chk("word_count_hold", 64'(word_count), 64'(exp_wc));
        chk("overflow_hold", 64'(overflow), 64'(exp_ov));
    endtask

    initial begin
        logic [31:0] gaps;
        int          sent;
        vectors     = 0;
        miscompares = 0;
        areset      = 1'b1;
        arm         = 1'b0;
        base_addr   = 10'd0;
        max_words   = 10'd0;
        tvalid      = 1'b0;
        tdata       = 64'd0;
        tlast       = 1'b0;
        step();
        step();
        areset = 1'b0;
        step();

        // Reset state
        chk("rst_tready", 64'(tready), 64'h0);
        chk("rst_bram_en", 64'(bram_en), 64'h0);
        chk("rst_bram_we", 64'(bram_we), 64'h0);
        chk("rst_bram_addr", 64'(bram_addr), 64'h0);
        chk("rst_bram_din", bram_din, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_word_count", 64'(word_count), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);

        // Basic 4-beat packet
        do_arm(10'h010, 10'd8);
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 64'hA0 + 64'(i), i == 3, 1'b1, 10'h010 + 10'(i));
        end
        chk_done(10'd4, 1'b0);

        // Address wrap at top of BRAM
        do_arm(10'h3FE, 10'd4);
        beat(1'b1, 64'h1111_0000_0000_0001, 1'b0, 1'b1, 10'h3FE);
        beat(1'b1, 64'h1111_0000_0000_0002, 1'b0, 1'b1, 10'h3FF);
        beat(1'b1, 64'h1111_0000_0000_0003, 1'b0, 1'b1, 10'h000);
        beat(1'b1, 64'h1111_0000_0000_0004, 1'b1, 1'b1, 10'h001);
        chk_done(10'd4, 1'b0);

        // Overflow: capacity 3, packet of 6
        do_arm(10'h100, 10'd3);
        beat(1'b1, 64'hB0, 1'b0, 1'b1, 10'h100);
        beat(1'b1, 64'hB1, 1'b0, 1'b1, 10'h101);
        beat(1'b1, 64'hB2, 1'b0, 1'b1, 10'h102);
        chk("ovf_set", 64'(overflow), 64'h1);
        chk("ovf_tready_drain", 64'(tready), 64'h1);
        beat(1'b1, 64'hB3, 1'b0, 1'b0, 10'h000);
        chk("ovf_wc_frozen", 64'(word_count), 64'd3);
        beat(1'b1, 64'hB4, 1'b0, 1'b0, 10'h000);
        chk("ovf_no_done_early", 64'(done), 64'h0);
        beat(1'b1, 64'hB5, 1'b1, 1'b0, 10'h000);
        chk_done(10'd3, 1'b1);

        // Exact fit: tlast on the max_words-th beat is not an overflow
        do_arm(10'h020, 10'd2);
        beat(1'b1, 64'hC0, 1'b0, 1'b1, 10'h020);
        beat(1'b1, 64'hC1, 1'b1, 1'b1, 10'h021);
        chk_done(10'd2, 1'b0);

        // Zero capacity goes straight to DONE
        do_arm(10'h055, 10'd0);
        chk_done(10'd0, 1'b0);

        // Gapped 16-beat packet with a stray arm pulse mid-transfer
        do_arm(10'h040, 10'd20);
        gaps = 32'h5A3C_96E1;
        sent = 0;
        for (int c = 0; c < 32 && sent < 16; c++) begin
            if (c == 5) begin
                arm       = 1'b1;
                base_addr = 10'h300;
                max_words = 10'd1;
            end else begin
                arm = 1'b0;
            end
            if (gaps[c]) begin
                beat(1'b1, 64'hD000 + 64'(sent), sent == 15, 1'b1, 10'h040 + 10'(sent));
                sent++;
            end else begin
                beat(1'b0, 64'hDEAD_BEEF, 1'b1, 1'b0, 10'h000);
                chk("gap_tready", 64'(tready), 64'h1);
            end
        end
        arm = 1'b0;
        chk_done(10'd16, 1'b0);

        // Reset mid-transfer, with a beat offered in the reset cycle
        do_arm(10'h080, 10'd8);
        beat(1'b1, 64'hE0, 1'b0, 1'b1, 10'h080);
        beat(1'b1, 64'hE1, 1'b0, 1'b1, 10'h081);
        beat(1'b1, 64'hE2, 1'b0, 1'b1, 10'h082);
        areset = 1'b1;
        beat(1'b1, 64'hE3, 1'b0, 1'b0, 10'h000);
        chk("mid_rst_tready", 64'(tready), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_word_count", 64'(word_count), 64'h0);
        chk("mid_rst_done", 64'(done), 64'h0);
        areset = 1'b0;
        do_arm(10'h090, 10'd8);
        beat(1'b1, 64'hF0, 1'b0, 1'b1, 10'h090);
        beat(1'b1, 64'hF1, 1'b1, 1'b1, 10'h091);
        chk_done(10'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
